// File: rtl/ember_pkg.sv
// Shared types and constants for the Ember instruction fetch front end.
package ember_pkg;

  typedef enum logic [1:0] {
    ST_WORD = 2'd0,
    ST_IMM  = 2'd1,
    ST_HOLD = 2'd2
  } fetch_state_e;

  localparam int IMM_BIT_DEF   = 27;
  localparam int INSTR_BYTES   = 4;
  localparam int IMM_BYTES     = 8;
  localparam int PC_STEP_NOIMM = 4;
  localparam int PC_STEP_IMM   = 12;

endpackage

// File: rtl/ember_fetch_if.sv
// Fetch front-end bus: imem read port, execute redirect and decode handshake.
interface ember_fetch_if #(
  parameter int ADDR_W = 16
) ();

  logic              imem_rd_en;
  logic [ADDR_W-1:0] imem_addr;
  logic [7:0]        imem_rdata;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              instr_valid;
  logic              instr_ready;
  logic [31:0]       instr_word;
  logic              instr_has_imm;
  logic [63:0]       instr_imm;
  logic [ADDR_W-1:0] instr_pc;

  modport master (
    output imem_rd_en, imem_addr,
    input  imem_rdata,
    input  redirect_valid, redirect_pc,
    output instr_valid, instr_word, instr_has_imm, instr_imm, instr_pc,
    input  instr_ready
  );

  modport slave (
    input  imem_rd_en, imem_addr,
    output imem_rdata,
    output redirect_valid, redirect_pc,
    input  instr_valid, instr_word, instr_has_imm, instr_imm, instr_pc,
    output instr_ready
  );

endinterface

// File: rtl/ember_byte_gather.sv
// N-byte little-endian assembly register: each write lands at the next byte lane.
module ember_byte_gather #(
  parameter int N  = 4,
  parameter int CW = $clog2(N + 1)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           clr_i,
  input  logic           wr_i,
  input  logic [7:0]     byte_i,
  output logic [8*N-1:0] data_o,
  output logic [CW-1:0]  cnt_o,
  output logic           done_o
);

  logic [8*N-1:0] data_q, data_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  assign data_o = data_q;
  assign cnt_o  = cnt_q;
  assign done_o = (cnt_q == CW'(N));

  always_comb begin
    data_d = data_q;
    cnt_d  = cnt_q;
    if (clr_i) begin
      data_d = {(8*N){1'b0}};
      cnt_d  = {CW{1'b0}};
    end else if (wr_i && !done_o) begin
      for (int i = 0; i < N; i++) begin
        if (cnt_q == CW'(i)) begin
          data_d[8*i +: 8] = byte_i;
        end else begin
          data_d[8*i +: 8] = data_q[8*i +: 8];
        end
      end
      cnt_d = cnt_q + CW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q <= {(8*N){1'b0}};
      cnt_q  <= {CW{1'b0}};
    end else begin
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/ember_fetch.sv
// Ember instruction fetch: byte reads from imem, 32-bit word plus optional 64-bit
// immediate, one instruction in flight, presented to decode over valid/ready.
module ember_fetch
  import ember_pkg::*;
#(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}},
  parameter int                IMM_BIT  = IMM_BIT_DEF
) (
  input  logic          clk,
  input  logic          reset,
  ember_fetch_if.master bus
);

  localparam int WCW = $clog2(INSTR_BYTES + 1);
  localparam int ICW = $clog2(IMM_BYTES + 1);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] ipc_q, ipc_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        iss_q, iss_d;
  logic              rd_en_q, rd_en_d;
  logic              cap_v_q, cap_v_d;
  logic              valid_q, valid_d;

  logic              w_clr, w_wr, w_done;
  logic              i_clr, i_wr, i_done;
  logic [WCW-1:0]    w_cnt;
  logic [ICW-1:0]    i_cnt;
  logic [31:0]       word_data, word_next;
  logic [63:0]       imm_data;
  logic [ADDR_W-1:0] step_s;

  ember_byte_gather #(.N(INSTR_BYTES)) u_word (
    .clk(clk), .reset(reset), .clr_i(w_clr), .wr_i(w_wr), .byte_i(bus.imem_rdata),
    .data_o(word_data), .cnt_o(w_cnt), .done_o(w_done)
  );

  ember_byte_gather #(.N(IMM_BYTES)) u_imm (
    .clk(clk), .reset(reset), .clr_i(i_clr), .wr_i(i_wr), .byte_i(bus.imem_rdata),
    .data_o(imm_data), .cnt_o(i_cnt), .done_o(i_done)
  );

  // The immediate flag is decided from the last word byte while it is still on rdata.
  assign word_next = {bus.imem_rdata, word_data[23:0]};
  assign step_s    = word_data[IMM_BIT] ? ADDR_W'(PC_STEP_IMM) : ADDR_W'(PC_STEP_NOIMM);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ipc_d   = ipc_q;
    addr_d  = addr_q;
    iss_d   = iss_q;
    rd_en_d = 1'b0;
    cap_v_d = rd_en_q;
    valid_d = valid_q;
    w_clr   = 1'b0;
    w_wr    = 1'b0;
    i_clr   = 1'b0;
    i_wr    = 1'b0;
    case (state_q)
      ST_WORD: begin
        if (iss_q < 4'(INSTR_BYTES)) begin
          rd_en_d = 1'b1;
          addr_d  = pc_q + ADDR_W'(iss_q);
          iss_d   = iss_q + 4'd1;
        end else begin
          iss_d = iss_q;
        end
        if (cap_v_q && !w_done) begin
          w_wr = 1'b1;
          if (w_cnt == WCW'(INSTR_BYTES - 1)) begin
            ipc_d = pc_q;
            if (word_next[IMM_BIT]) begin
              state_d = ST_IMM;
              rd_en_d = 1'b1;
              addr_d  = pc_q + ADDR_W'(INSTR_BYTES);
              iss_d   = 4'd1;
            end else begin
              state_d = ST_HOLD;
              valid_d = 1'b1;
              iss_d   = 4'd0;
            end
          end else begin
            ipc_d = ipc_q;
          end
        end else begin
          w_wr = 1'b0;
        end
      end
      ST_IMM: begin
        if (iss_q < 4'(IMM_BYTES)) begin
          rd_en_d = 1'b1;
          addr_d  = pc_q + ADDR_W'(INSTR_BYTES) + ADDR_W'(iss_q);
          iss_d   = iss_q + 4'd1;
        end else begin
          iss_d = iss_q;
        end
        if (cap_v_q && !i_done) begin
          i_wr = 1'b1;
          if (i_cnt == ICW'(IMM_BYTES - 1)) begin
            state_d = ST_HOLD;
            valid_d = 1'b1;
            iss_d   = 4'd0;
          end else begin
            state_d = ST_IMM;
          end
        end else begin
          i_wr = 1'b0;
        end
      end
      ST_HOLD: begin
        if (bus.instr_ready) begin
          pc_d    = pc_q + step_s;
          state_d = ST_WORD;
          valid_d = 1'b0;
          rd_en_d = 1'b1;
          addr_d  = pc_q + step_s;
          iss_d   = 4'd1;
          w_clr   = 1'b1;
          i_clr   = 1'b1;
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        state_d = ST_WORD;
        iss_d   = 4'd0;
        valid_d = 1'b0;
      end
    endcase
    // Redirect wins over everything, including a same-cycle decode handshake.
    if (bus.redirect_valid) begin
      pc_d    = bus.redirect_pc & {{(ADDR_W-2){1'b1}}, 2'b00};
      state_d = ST_WORD;
      valid_d = 1'b0;
      rd_en_d = 1'b1;
      addr_d  = bus.redirect_pc & {{(ADDR_W-2){1'b1}}, 2'b00};
      iss_d   = 4'd1;
      cap_v_d = 1'b0;
      w_clr   = 1'b1;
      i_clr   = 1'b1;
    end else begin
      cap_v_d = cap_v_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_WORD;
      pc_q    <= RESET_PC;
      ipc_q   <= {ADDR_W{1'b0}};
      addr_q  <= {ADDR_W{1'b0}};
      iss_q   <= 4'd0;
      rd_en_q <= 1'b0;
      cap_v_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ipc_q   <= ipc_d;
      addr_q  <= addr_d;
      iss_q   <= iss_d;
      rd_en_q <= rd_en_d;
      cap_v_q <= cap_v_d;
      valid_q <= valid_d;
    end
  end

  assign bus.imem_rd_en    = rd_en_q;
  assign bus.imem_addr     = addr_q;
  assign bus.instr_valid   = valid_q;
  assign bus.instr_word    = word_data;
  assign bus.instr_has_imm = word_data[IMM_BIT];
  assign bus.instr_imm     = imm_data;
  assign bus.instr_pc      = ipc_q;

endmodule

// File: doc/ember_fetch.md
Name: ember_fetch

Overview:
- Instruction fetch front end for the Ember core: the reader side of the byte-wide instruction memory (imem).
- Reads little-endian bytes from imem and assembles 32-bit instruction words.
- When a word's immediate-present bit is set, also reads the following 64-bit little-endian immediate.
- Presents each instruction to decode over a valid/ready handshake and tracks the PC, including redirects from execute.

Parameters:
ADDR_W, 16, imem byte-address width; all PC/address arithmetic is modulo 2^ADDR_W
RESET_PC, 0, PC loaded on reset
IMM_BIT, 27, bit of the instruction word that flags a trailing 64-bit immediate (bit 3 of byte 3)

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
imem_rd_en  out  1  byte read request
imem_addr  out  ADDR_W  byte address of the request
imem_rdata  in  8  read data, valid exactly 1 cycle after imem_rd_en (synchronous read)
redirect_valid  in  1  load a new PC and abort the current fetch
redirect_pc  in  ADDR_W  new PC; bits [1:0] are forced to 0
instr_valid  out  1  instruction available
instr_ready  in  1  decode accepts the instruction
instr_word  out  32  assembled instruction word
instr_has_imm  out  1  instr_word[IMM_BIT]
instr_imm  out  64  immediate; 0 when instr_has_imm=0
instr_pc  out  ADDR_W  address of instr_word byte 0

Behaviour:
- Reset, asynchronous: state=WORD, pc=RESET_PC, byte counters=0, and all outputs low/zero (imem_rd_en, imem_addr, instr_*). The first read issues in the first cycle after reset drops.
- Reset mid-operation discards any partial assembly; returned data from in-flight reads is ignored.
- States:
  - WORD: issue reads of pc..pc+3 in 4 consecutive cycles. Capture byte i one cycle after its issue, at bit position 8*i. After byte 3 is captured, the next cycle goes to IMM if word[IMM_BIT]=1, else to HOLD.
  - IMM: issue reads of pc+4..pc+11 in 8 consecutive cycles. Capture byte j into instr_imm[8*j+7:8*j] (little-endian). After the last capture, go to HOLD.
  - HOLD: instr_valid=1, all instr_* outputs stable. Once instr_valid and instr_ready are both high, set pc += 4 or 12 and go to WORD; the next read issues in the following cycle.
- Timing, with fetch start at cycle 0:
  - Without immediate: reads at cycles 0-3; instr_valid high at cycle 5.
  - With immediate: IMM reads at cycles 5-12; instr_valid high at cycle 14.
  - instr_valid never asserts outside HOLD.
  - No prefetch: at most one instruction is in flight.
- Backpressure: instr_valid and the data stay held indefinitely while instr_ready=0. imem_rd_en=0 in HOLD.
- Redirect (any state):
  - Next cycle: pc = {redirect_pc[ADDR_W-1:2],2'b00}, state=WORD, instr_valid=0, counters cleared.
  - Read data returning in the cycle after the redirect is discarded.
  - A redirect in the same cycle as a HOLD handshake: the transfer counts as accepted, then the redirect PC wins over pc+4/12.
- Wrap: byte addresses and PC increments wrap modulo 2^ADDR_W, so an instruction or immediate may straddle the top of memory.
- imem_addr holds its last value when imem_rd_en=0.

Decomposition:
- ember_pkg holds: state enum (WORD, IMM, HOLD); IMM_BIT default; constants INSTR_BYTES=4, IMM_BYTES=8, PC_STEP_NOIMM=4, PC_STEP_IMM=12.
- One natural sub-module, ember_byte_gather: a parameterised N-byte little-endian shift/insert register with a byte counter and a done flag. It is instantiated twice, N=4 for the word and N=8 for the immediate.

Test Plan:
- imem[0..3]=01 12 00 00, reset released, instr_ready=1 -> reads at addresses 0-3; at cycle 5 instr_valid=1, instr_word=0x00001201, instr_has_imm=0, instr_imm=0, instr_pc=0.
- imem[4..15]=00 01 00 08 34 12 00 00 00 00 00 00 following that word -> instr_word=0x08000100, instr_has_imm=1, instr_imm=0x0000000000001234, instr_pc=4, valid 14 cycles after its fetch start; the next fetch starts at 0x10.
- instr_ready=0 for 20 cycles in HOLD -> instr_valid and all data stable, imem_rd_en=0; raising ready completes exactly one transfer.
- redirect_valid with redirect_pc=0x0042 during IMM byte 5 -> no instr_valid for the aborted instruction; the next reads start at 0x0040; returned stale data is ignored.
- ADDR_W=16, redirect to 0xFFFC with word FF..FC = 00 01 00 08 and imm at 0000-0007 -> reads wrap to 0x0000, imm assembled correctly, next pc=0x0008.
- reset asserted mid-WORD (after 2 bytes) -> all outputs 0 immediately; after release, fetch restarts at RESET_PC with no corrupted word.
